udm_uart_tx: RTL

//  Buffered UART byte transmitter: drives the serial line from the SoC toward the host (board UART_RXD_OUT).
//  It is the transmit-direction counterpart of the SoC serial receive path.

---
 rtl/udm_uart_tx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/udm_uart_tx.sv
// Buffered UART transmitter: a byte FIFO feeds a 16-bit-timed FSM that serialises
// 8-bit frames LSB first, with optional parity and one or two stop bits.
module udm_uart_tx #(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk_i,
  input  logic                          arst_ni,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t             state_q, state_d;
  logic [15:0]        timer_q, timer_d;
  logic [2:0]         idx_q, idx_d;
  logic               tx_q, tx_d;
  logic [7:0]         sh_q, sh_d;
  logic               par_q;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [7:0]         head;
  logic               push, pop, timer_done, fifo_nempty;

  assign head        = mem[rd_ptr_q];
  assign ready_o     = (cnt_q != CNT_W'(FIFO_DEPTH));
  assign push        = valid_i & ready_o;
  assign fifo_nempty = (cnt_q != '0);
  assign timer_done  = (timer_q == '0);
  assign tx_o        = tx_q;
  assign busy_o      = (state_q != S_IDLE) | fifo_nempty;
  assign fifo_cnt_o  = cnt_q;

  // Control state: FSM, bit timer, bit/stop index, line driver, FIFO pointers
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Datapath storage carries no reset; it is always loaded before use
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= data_i;
    sh_q <= sh_d;
    if (pop) par_q <= (^head) ^ 1'(PARITY_ODD);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (fifo_nempty) state_d = S_START;
      S_START:  if (timer_done) state_d = S_DATA;
      S_DATA:   if (timer_done && idx_q == 3'd7)
                  state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (timer_done) state_d = S_STOP;
      S_STOP:   if (timer_done && idx_q == STOP_LAST)
                  state_d = fifo_nempty ? S_START : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Registered outputs: next line level, timer reload, shift and FIFO pop
  always_comb begin
    tx_d    = tx_q;
    timer_d = timer_done ? timer_q : timer_q - 16'd1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d    = 1'b1;
        timer_d = '0;
        if (fifo_nempty) begin
          pop     = 1'b1;
          sh_d    = head;
          tx_d    = 1'b0;
          timer_d = BIT_LAST;
        end
      end
      S_START: if (timer_done) begin
        tx_d    = sh_q[0];
        idx_d   = '0;
        timer_d = BIT_LAST;
      end
      S_DATA: if (timer_done) begin
        timer_d = BIT_LAST;
        if (idx_q == 3'd7) begin
          idx_d = '0;
          tx_d  = (PARITY_EN != 0) ? par_q : 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
          sh_d  = {1'b0, sh_q[7:1]};
          tx_d  = sh_q[1];
        end
      end
      S_PARITY: if (timer_done) begin
        tx_d    = 1'b1;
        idx_d   = '0;
        timer_d = BIT_LAST;
      end
      S_STOP: if (timer_done) begin
        // The stop index counts whole stop bits so the timer never needs more than 16 bits
        if (idx_q != STOP_LAST) begin
          idx_d   = idx_q + 3'd1;
          timer_d = BIT_LAST;
        end else if (fifo_nempty) begin
          pop     = 1'b1;
          sh_d    = head;
          tx_d    = 1'b0;
          idx_d   = '0;
          timer_d = BIT_LAST;
        end else begin
          tx_d  = 1'b1;
          idx_d = '0;
        end
      end
      default: tx_d = 1'b1;
    endcase
  end

endmodule
